// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (requester C, priority) and the auxiliary loader/debug port (requester A).
// Fixed priority to C. A starvation counter forces one grant to A after
// STARVE_LIMIT consecutive lost cycles. Read data returns one cycle after the
// grant, and rvalid is steered to the port that issued the read.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata      core request, held until granted
//   c_gnt, c_stall                 core grant (comb), pipeline hold (c_req & ~c_gnt)
//   c_rvalid, c_rdata              core read return (rdata = mem_dout)
//   a_req/a_we/a_addr/a_wdata      auxiliary request, held until granted
//   a_gnt                          auxiliary grant (comb)
//   a_rvalid, a_rdata              auxiliary read return (rdata = mem_dout)
//   mem_we/mem_addr/mem_din        drive to dmem; all zero when nothing is granted
//   mem_dout                       dmem read data, valid the cycle after the address

module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_stall,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;  // 0 = C, 1 = A
  logic       force_a;

  // Arbitration: A wins when C is idle or when A has waited its limit.
  always_comb begin
    force_a = (starve_cnt_q == StarveMax);
    a_gnt   = ~reset & a_req & (~c_req | force_a);
    c_gnt   = ~reset & c_req & ~a_gnt;
  end

  assign c_stall = c_req & ~c_gnt;

  // Winner drives the memory port; idle port is held at zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (a_gnt) begin
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_din  = a_wdata;
    end else if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_din  = c_wdata;
    end
  end

  // Counter clears on any A grant or when A stops asking; saturates at the limit,
  // though force_a guarantees a grant (and clear) once the limit is reached.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (a_gnt || !a_req) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rd_pend_d  = (a_gnt & ~a_we) | (c_gnt & ~c_we);
    rd_owner_d = a_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Masking with reset drops a read whose return would land in a reset cycle.
  assign c_rvalid = rd_pend_q & ~rd_owner_q & ~reset;
  assign a_rvalid = rd_pend_q & rd_owner_q & ~reset;
  assign c_rdata  = mem_dout;
  assign a_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt, c_stall, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          a_req, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  dmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_gnt   (c_gnt),
    .c_stall (c_stall),
    .c_rvalid(c_rvalid),
    .c_rdata (c_rdata),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_gnt   (a_gnt),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous dmem: data for an address appears next cycle.
  logic [DW-1:0] tb_mem [1 << AW];
  always @(posedge clk) begin
    mem_dout <= tb_mem[mem_addr];
    if (mem_we) tb_mem[mem_addr] = mem_din;
  end

  // Reference model: expected memory contents, A's lost-cycle count and the
  // read expected to come back next cycle.
  logic [DW-1:0] ref_mem [1 << AW];
  int unsigned   m_lost;
  bit            m_pend_v, m_pend_owner;
  logic [DW-1:0] m_pend_data;
  bit            m_c_gnt, m_a_gnt;

  // Values observed mid-cycle by the last step.
  logic          obs_c_gnt, obs_a_gnt, obs_c_stall, obs_c_rvalid, obs_a_rvalid, obs_mem_we;
  logic [DW-1:0] obs_c_rdata, obs_a_rdata, obs_mem_din;
  logic [AW-1:0] obs_mem_addr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model, then
  // advances the model and the clock.
  task automatic step(input bit rst,
                      input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bit            ea, ec, ecv, eav, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    reset = rst;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    #4;
    ea  = !rst && ar && (!cr || m_lost == LIMIT);
    ec  = !rst && cr && !ea;
    ecv = !rst && m_pend_v && !m_pend_owner;
    eav = !rst && m_pend_v && m_pend_owner;
    ewe = 1'b0; eaddr = '0; edin = '0;
    if (ea) begin
      ewe = aw; eaddr = aa; edin = ad;
    end else if (ec) begin
      ewe = cw; eaddr = ca; edin = cd;
    end
    obs_c_gnt = c_gnt; obs_a_gnt = a_gnt; obs_c_stall = c_stall;
    obs_c_rvalid = c_rvalid; obs_a_rvalid = a_rvalid; obs_mem_we = mem_we;
    obs_c_rdata = c_rdata; obs_a_rdata = a_rdata; obs_mem_din = mem_din; obs_mem_addr = mem_addr;
    check("c_gnt", c_gnt, ec);
    check("a_gnt", a_gnt, ea);
    check("c_stall", c_stall, cr && !ec);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, eaddr);
    check("mem_din", mem_din, edin);
    check("c_rvalid", c_rvalid, ecv);
    check("a_rvalid", a_rvalid, eav);
    if (ecv) check("c_rdata", c_rdata, m_pend_data);
    if (eav) check("a_rdata", a_rdata, m_pend_data);
    m_c_gnt = ec;
    m_a_gnt = ea;
    if (rst) begin
      m_lost   = 0;
      m_pend_v = 1'b0;
    end else begin
      m_lost   = (ar && !ea) ? m_lost + 1 : 0;
      m_pend_v = (ea && !aw) || (ec && !cw);
      m_pend_owner = ea;
      if (m_pend_v) m_pend_data = ref_mem[eaddr];
      if (ewe) ref_mem[eaddr] = edin;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit            cp_v, cp_we, ap_v, ap_we, rst;
    logic [AW-1:0] cp_addr, ap_addr;
    logic [DW-1:0] cp_data, ap_data, word1;

    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[10'h010]  = 32'hDEADBEEF;
    ref_mem[10'h010] = 32'hDEADBEEF;
    m_lost = 0; m_pend_v = 1'b0; m_pend_owner = 1'b0; m_pend_data = '0;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    @(posedge clk);
    #1;
    idle(1);
    idle(1);

    // C reads 0x010 right after reset.
    step(0, 1, 0, 10'h010, '0, 0, 0, '0, '0);
    check("t1 c_gnt", obs_c_gnt, 1);
    idle(0);
    check("t1 c_rvalid", obs_c_rvalid, 1);
    check("t1 c_rdata", obs_c_rdata, 32'hDEADBEEF);
    check("t1 a_rvalid", obs_a_rvalid, 0);

    // A alone writes then reads 0x3FF.
    step(0, 0, 0, '0, '0, 1, 1, 10'h3FF, 32'hCAFEF00D);
    check("t2 mem_we", obs_mem_we, 1);
    step(0, 0, 0, '0, '0, 1, 0, 10'h3FF, '0);
    check("t2 no rvalid after write", obs_a_rvalid, 0);
    idle(0);
    check("t2 a_rvalid", obs_a_rvalid, 1);
    check("t2 a_rdata", obs_a_rdata, 32'hCAFEF00D);

    // Continuous contention: C,C,C,C,A repeating.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 10'h020, 32'h11110000, 1, 1, 10'h030, 32'h22220000);
      check("t3 a_gnt pattern", obs_a_gnt, (i % 5) == 4);
      check("t3 c_stall pattern", obs_c_stall, (i % 5) == 4);
    end
    idle(0);

    // Back-to-back reads from alternating owners.
    word1 = ref_mem[10'h001];
    step(0, 1, 0, 10'h001, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 1, 0, 10'h002, '0);
    check("t4 c_rvalid", obs_c_rvalid, 1);
    check("t4 c_rdata", obs_c_rdata, word1);
    check("t4 a_rvalid early", obs_a_rvalid, 0);
    idle(0);
    check("t4 a_rvalid", obs_a_rvalid, 1);
    check("t4 c_rvalid overlap", obs_c_rvalid, 0);

    // Reset right after a granted read drops the read.
    step(0, 1, 0, 10'h005, '0, 0, 0, '0, '0);
    idle(1);
    check("t5 c_rvalid in reset", obs_c_rvalid, 0);
    idle(0);
    check("t5 c_rvalid after", obs_c_rvalid, 0);
    check("t5 a_rvalid after", obs_a_rvalid, 0);
    check("t5 gnts after", {obs_c_gnt, obs_a_gnt}, 0);
    check("t5 mem drive after", {obs_mem_we, obs_mem_addr, obs_mem_din}, 0);

    // A starved to 3, drops for one cycle, then needs 4 more denials.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 10'h040, 32'h1, 1, 1, 10'h041, 32'h2);
    step(0, 1, 1, 10'h040, 32'h1, 0, 0, '0, '0);
    check("t6 a_gnt while dropped", obs_a_gnt, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 10'h040, 32'h1, 1, 1, 10'h041, 32'h2);
      check("t6 a_gnt restart", obs_a_gnt, i == 4);
    end
    idle(0);

    // Random traffic with requests held until granted.
    cp_v = 0; ap_v = 0;
    cp_we = 0; ap_we = 0; cp_addr = '0; ap_addr = '0; cp_data = '0; ap_data = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!cp_v && $urandom_range(0, 2) != 0) begin
        cp_v = 1; cp_we = 1'($urandom_range(0, 1));
        cp_addr = 10'($urandom_range(0, 15)); cp_data = $urandom;
      end
      if (!ap_v && $urandom_range(0, 3) == 0) begin
        ap_v = 1; ap_we = 1'($urandom_range(0, 1));
        ap_addr = 10'($urandom_range(0, 15)); ap_data = $urandom;
      end else if (ap_v && $urandom_range(0, 15) == 0) begin
        ap_v = 0;
      end
      rst = ($urandom_range(0, 99) == 0);
      step(rst, cp_v, cp_we, cp_addr, cp_data, ap_v, ap_we, ap_addr, ap_data);
      if (m_c_gnt) cp_v = 0;
      if (m_a_gnt) ap_v = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
